// File: rtl/butterfly_feeder.sv
// Operand feeder for the last radix-2 DIT stage of an 8-point FFT.
// Buffers one 8-sample complex frame, then presents pairs (x[k], x[k+4]) with W8^k.
module butterfly_feeder #(
  parameter int n   = 32,
  parameter int d   = 16,
  parameter int W45 = 46341
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] recv_r,
  input  logic [n-1:0] recv_c,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] ar,
  output logic [n-1:0] ac,
  output logic [n-1:0] br,
  output logic [n-1:0] bc,
  output logic [n-1:0] wr,
  output logic [n-1:0] wc,
  output logic [1:0]   k_idx
);

  localparam int unsigned DEPTH = 8;

  localparam logic [n-1:0] TW_ZERO  = '0;
  localparam logic [n-1:0] TW_P_ONE = n'(64'(1) << d);
  localparam logic [n-1:0] TW_M_ONE = n'(-(64'(1) << d));
  localparam logic [n-1:0] TW_P_45  = n'(W45);
  localparam logic [n-1:0] TW_M_45  = n'(-W45);

  typedef enum logic {
    LOAD  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [2:0]   r_wr_cnt;
  logic [2:0]   w_wr_cnt_nxt;
  logic [1:0]   r_k;
  logic [1:0]   w_k_nxt;
  logic         w_wr_en;
  logic [n-1:0] r_buf_r [DEPTH];
  logic [n-1:0] r_buf_c [DEPTH];

  // State, write pointer and pair index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= LOAD;
      r_wr_cnt <= 3'd0;
      r_k      <= 2'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_cnt <= w_wr_cnt_nxt;
      r_k      <= w_k_nxt;
    end
  end

  // Single frame buffer; cleared on reset so stale data never leaks out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_buf_r[i] <= '0;
        r_buf_c[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_buf_r[r_wr_cnt] <= recv_r;
      r_buf_c[r_wr_cnt] <= recv_c;
    end
  end

  // Next-state and handshake control
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_cnt_nxt = r_wr_cnt;
    w_k_nxt      = r_k;
    w_wr_en      = 1'b0;
    recv_rdy     = 1'b0;
    send_val     = 1'b0;
    case (r_state)
      LOAD: begin
        recv_rdy = 1'b1;
        if (recv_val) begin
          w_wr_en      = 1'b1;
          w_wr_cnt_nxt = r_wr_cnt + 3'd1;
          if (r_wr_cnt == 3'd7) begin
            w_state_nxt = ISSUE;
            w_k_nxt     = 2'd0;
          end
        end
      end
      ISSUE: begin
        send_val = 1'b1;
        if (send_rdy) begin
          w_k_nxt = r_k + 2'd1;
          if (r_k == 2'd3) begin
            w_state_nxt = LOAD;
          end
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  // Operand and twiddle presentation; forced to zero outside ISSUE
  always_comb begin
    ar    = '0;
    ac    = '0;
    br    = '0;
    bc    = '0;
    wr    = '0;
    wc    = '0;
    k_idx = 2'd0;
    if (r_state == ISSUE) begin
      ar    = r_buf_r[{1'b0, r_k}];
      ac    = r_buf_c[{1'b0, r_k}];
      br    = r_buf_r[{1'b1, r_k}];
      bc    = r_buf_c[{1'b1, r_k}];
      k_idx = r_k;
      case (r_k)
        2'd0: begin wr = TW_P_ONE; wc = TW_ZERO;  end
        2'd1: begin wr = TW_P_45;  wc = TW_M_45;  end
        2'd2: begin wr = TW_ZERO;  wc = TW_M_ONE; end
        default: begin wr = TW_M_45; wc = TW_M_45; end
      endcase
    end
  end

endmodule

// File: doc/butterfly_feeder.md
BUTTERFLY_FEEDER -- requirements
Module: butterfly_feeder

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low, with ports named clk and reset.
REQ-002 Parameter n, default 32: fixed-point word width in bits, two's complement.
REQ-003 Parameter d, default 16: fractional bits.
REQ-004 Parameter W45, default 46341: round(cos(pi/4) * 2^d) for d=16.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port reset  input  1  asynchronous reset, asserted when 0.
REQ-007 Port recv_val  input  1  input sample valid.
REQ-008 Port recv_rdy  output  1  block can accept a sample.
REQ-009 Port recv_r, recv_c  input  n each  real and imaginary parts of the input sample.
REQ-010 Port send_val  output  1  butterfly operand set valid.
REQ-011 Port send_rdy  input  1  downstream butterfly accepts the operand set.
REQ-012 Port ar, ac, br, bc  output  n each  operands a and b (real and imaginary).
REQ-013 Port wr, wc  output  n each  twiddle W8^k (real and imaginary).
REQ-014 Port k_idx  output  2  index k of the pair currently presented.

Function
REQ-015 The block SHALL feed the final radix-2 DIT stage of an 8-point FFT: it buffers 8 complex samples x[0..7], then issues 4 operand sets k=0..3 with a=x[k], b=x[k+4], w=W8^k.
REQ-016 Twiddles SHALL be constants: k0=(2^d, 0); k1=(W45, -W45); k2=(0, -2^d); k3=(-W45, -W45). Negative values are n-bit two's complement.
REQ-017 The FSM SHALL have two states, LOAD and ISSUE.
REQ-018 In LOAD: recv_rdy=1 and send_val=0.
REQ-019 In ISSUE: recv_rdy=0 and send_val=1.
REQ-020 A receive handshake (recv_val & recv_rdy at a rising edge) SHALL write the sample into x[wr_cnt] and increment the 3-bit wr_cnt.
REQ-021 The handshake that writes x[7] SHALL move the FSM to ISSUE with k=0 on the same edge; wr_cnt wraps to 0.
REQ-022 In ISSUE, ar/ac/br/bc/wr/wc/k_idx SHALL be driven combinationally from the buffer and from k.
REQ-023 A send handshake (send_val & send_rdy) SHALL increment k.
REQ-024 The handshake at k=3 SHALL return the FSM to LOAD with k=0.
REQ-025 First sample of the next frame SHALL be accepted no earlier than 1 cycle after the last send handshake (single buffer; no overlap).
REQ-026 Latency: first operand set valid 1 cycle after the 8th receive handshake.
REQ-027 Throughput: one frame per 12 cycles minimum (8 load + 4 issue) with both handshake sides always ready.
REQ-028 While send_rdy=0 in ISSUE, all outputs SHALL hold stable; k and the buffer SHALL not change.
REQ-029 recv_val in ISSUE SHALL be ignored; no buffer write and no counter change.
REQ-030 When send_val=0, ar, ac, br, bc, wr, wc and k_idx SHALL be driven to 0.
REQ-031 No arithmetic is performed; data SHALL pass through bit-exact.

Reset
REQ-032 reset=0 SHALL immediately force: state LOAD, wr_cnt=0, k=0, send_val=0, recv_rdy=1, all data outputs 0.
REQ-033 Buffer contents SHALL be cleared to 0 on reset.
REQ-034 Handshakes sampled while reset=0 SHALL have no effect.
REQ-035 Reset asserted mid-LOAD or mid-ISSUE SHALL discard the partial frame; after release the next accepted sample is x[0].

Verification
REQ-036 Basic frame: load x[i]=(i*2^16, -i*2^16), send_rdy=1 -> k=0: a=(0,0), b=(0x40000,0xFFFC0000), w=(0x10000,0); k=1: a=(0x10000,0xFFFF0000), b=(0x50000,0xFFFB0000), w=(0xB505,0xFFFF4AFB); k=2: w=(0,0xFFFF0000); k=3: w=(0xFFFF4AFB,0xFFFF4AFB); recv_rdy returns to 1 after the 4th send.
REQ-037 Backpressure: send_rdy=0 for 5 cycles at k=2 -> outputs and k_idx=2 stable for all 5 cycles, then proceed to k=3.
REQ-038 Input gaps: recv_val toggled 1/0 across the 8 samples -> exactly 8 writes, correct x ordering, send_val asserts 1 cycle after the last write.
REQ-039 Reset mid-frame: reset=0 after 5 samples, then 8 new samples -> operands come only from the new samples.
REQ-040 Reset mid-ISSUE: reset=0 at k=1 -> send_val=0 and recv_rdy=1 immediately; the next frame starts at x[0].
REQ-041 Back-to-back frames with recv_val=1 continuously -> second frame is correct; no sample is accepted while in ISSUE.
